// File: rtl/duty_ramp.sv
// duty_ramp: steps a registered PWM duty value toward an accepted target,
// one step every (step_interval+1) cycles, with hold/freeze and a done pulse.
module duty_ramp #(
  parameter int BITS      = 4,
  parameter int STEP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 target_valid,
  output logic                 target_ready,
  input  logic [BITS:0]        target,
  input  logic [BITS:0]        step_size,
  input  logic [STEP_BITS-1:0] step_interval,
  input  logic                 hold,
  output logic [BITS:0]        duty,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  // Full-scale duty (2^BITS), the largest value the PWM stage understands.
  localparam logic [BITS:0] DMAX = {1'b1, {BITS{1'b0}}};
  localparam logic [BITS:0] ONE  = {{BITS{1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [BITS:0]        duty_q, duty_d;
  logic [BITS:0]        tgt_q, tgt_d;
  logic [BITS:0]        step_q, step_d;
  logic [STEP_BITS-1:0] intv_q, intv_d;
  logic [STEP_BITS-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;

  logic [BITS:0]        tgt_clamp;
  logic [BITS:0]        step_eff;
  logic [BITS+1:0]      sum_up;     // one extra bit so duty+step never wraps
  logic [BITS:0]        gap_dn;
  logic [BITS:0]        step_duty;

  assign target_ready = (state_q == IDLE);
  assign busy         = (state_q == RAMP);
  assign duty         = duty_q;
  assign done         = done_q;

  // Input conditioning and the candidate duty for the next step edge.
  always_comb begin
    tgt_clamp = (target > DMAX) ? DMAX : target;
    step_eff  = (step_size == '0) ? ONE : step_size;
    sum_up    = {1'b0, duty_q} + {1'b0, step_q};
    gap_dn    = duty_q - tgt_q;
    step_duty = duty_q;
    if (duty_q < tgt_q)
      step_duty = (sum_up >= {1'b0, tgt_q}) ? tgt_q : sum_up[BITS:0];
    else if (duty_q > tgt_q)
      step_duty = (gap_dn <= step_q) ? tgt_q : (duty_q - step_q);
  end

  // Next-state logic: acceptance in IDLE, interval counting and stepping in RAMP.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    intv_d  = intv_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (target_valid) begin
          tgt_d  = tgt_clamp;
          step_d = step_eff;
          intv_d = step_interval;
          cnt_d  = '0;
          if (tgt_clamp == duty_q) done_d  = 1'b1;
          else                     state_d = RAMP;
        end
      end
      RAMP: begin
        if (!hold) begin
          if (cnt_q == intv_q) begin
            cnt_d  = '0;
            duty_d = step_duty;
            if (step_duty == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + STEP_BITS'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over any acceptance in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      intv_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      intv_q  <= intv_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// Bench for duty_ramp (BITS=4, STEP_BITS=8): directed scenarios followed by
// random traffic, all compared each cycle against a countdown-based model.
module tb_duty_ramp;

  logic       clk = 1'b0;
  logic       reset;
  logic       target_valid;
  logic       target_ready;
  logic [4:0] target;
  logic [4:0] step_size;
  logic [7:0] step_interval;
  logic       hold;
  logic [4:0] duty;
  logic       busy;
  logic       done;

  int total  = 0;
  int passed = 0;

  // Model state: ramping flag, duty, goal, step, interval, edges until next step.
  int m_busy, m_duty, m_tgt, m_step, m_int, m_wait, m_done;

  duty_ramp #(.BITS(4), .STEP_BITS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .target       (target),
    .step_size    (step_size),
    .step_interval(step_interval),
    .hold         (hold),
    .duty         (duty),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advance one clock: update the model from the inputs seen at this edge,
  // then compare every output just after the edge.
  task automatic tick();
    int nd;
    nd = 0;
    if (reset) begin
      m_busy = 0; m_duty = 0; m_tgt = 0; m_step = 0; m_int = 0; m_wait = 0;
    end else if (!m_busy) begin
      if (target_valid) begin
        m_tgt  = (int'(target) > 16) ? 16 : int'(target);
        m_step = (step_size == 0) ? 1 : int'(step_size);
        m_int  = int'(step_interval);
        if (m_tgt == m_duty) nd = 1;
        else begin
          m_busy = 1;
          m_wait = m_int + 1;
        end
      end
    end else if (!hold) begin
      m_wait--;
      if (m_wait == 0) begin
        if (m_duty < m_tgt) m_duty = (m_duty + m_step > m_tgt) ? m_tgt : m_duty + m_step;
        else                m_duty = (m_duty - m_step < m_tgt) ? m_tgt : m_duty - m_step;
        if (m_duty == m_tgt) begin
          m_busy = 0;
          nd = 1;
        end else m_wait = m_int + 1;
      end
    end
    m_done = nd;
    @(posedge clk);
    #1;
    chk("duty",  int'(duty),         m_duty);
    chk("busy",  int'(busy),         m_busy);
    chk("ready", int'(target_ready), 1 - m_busy);
    chk("done",  int'(done),         m_done);
  endtask

  task automatic offer(input int t, input int s, input int iv);
    target = 5'(t); step_size = 5'(s); step_interval = 8'(iv);
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; target_valid = 1'b0; target = '0; step_size = '0;
    step_interval = '0; hold = 1'b0;
    m_busy = 0; m_duty = 0; m_tgt = 0; m_step = 0; m_int = 0; m_wait = 0; m_done = 0;

    // Reset state; ready in the first cycle after reset.
    do_reset();
    chk("rst_duty",  int'(duty), 0);
    chk("rst_ready", int'(target_ready), 1);

    // 0 -> 12 by 4, interval 2: steps at edges 3, 6, 9.
    offer(12, 4, 2);
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 3) chk("up_e3", int'(duty), 4);
      if (e == 6) chk("up_e6", int'(duty), 8);
      if (e == 9) begin
        chk("up_e9", int'(duty), 12);
        chk("up_done", int'(done), 1);
        chk("up_busy", int'(busy), 0);
      end
    end
    tick();
    chk("done_once", int'(done), 0);

    // Target equal to current duty: no ramp, done next cycle.
    offer(12, 3, 5);
    chk("eq_busy", int'(busy), 0);
    chk("eq_done", int'(done), 1);
    tick();

    // Up to 16, then down to 3 by 5 with interval 0: 11, 6, 3.
    offer(16, 4, 0);
    tick();
    chk("to16", int'(duty), 16);
    offer(3, 5, 0);
    tick(); chk("dn1", int'(duty), 11);
    tick(); chk("dn2", int'(duty), 6);
    tick(); chk("dn3", int'(duty), 3);
    tick(); chk("dn_hold3", int'(duty), 3);

    // Over-range target clamps to 16 in one step of 16.
    do_reset();
    offer(31, 16, 0);
    chk("clamp_busy", int'(busy), 1);
    tick();
    chk("clamp_duty", int'(duty), 16);
    chk("clamp_done", int'(done), 1);

    // Hold for 5 cycles mid-ramp stretches a 9-edge ramp to 14 edges.
    do_reset();
    offer(12, 4, 2);
    for (int i = 0; i < 4; i++) tick();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_duty", int'(duty), 4);
    end
    hold = 1'b0;
    n = 9;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("hold_len", n, 14);

    // Step size 0 acts as 1; offers during RAMP are ignored; reset aborts.
    do_reset();
    offer(12, 0, 1);
    for (int i = 0; i < 4; i++) begin
      target_valid = 1'b1; target = 5'd2; step_size = 5'd9; step_interval = 8'd0;
      tick();
    end
    target_valid = 1'b0;
    chk("step1_duty", int'(duty), 2);
    chk("ignored_busy", int'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_duty", int'(duty), 0);
    chk("abort_busy", int'(busy), 0);
    tick();
    chk("abort_nodone", int'(done), 0);

    // Reset wins over a simultaneous offer.
    reset = 1'b1;
    target_valid = 1'b1; target = 5'd9; step_size = 5'd1; step_interval = 8'd0;
    tick();
    reset = 1'b0; target_valid = 1'b0;
    tick();
    chk("rst_prio", int'(busy), 0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      reset         = ($urandom_range(0, 149) == 0);
      target_valid  = ($urandom_range(0, 2) == 0);
      target        = 5'($urandom_range(0, 31));
      step_size     = 5'($urandom_range(0, 31) >> $urandom_range(0, 3));
      step_interval = 8'($urandom_range(0, 3));
      hold          = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/duty_ramp.md
DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 Parameter BITS, default 4, width of the downstream PWM counter; duty range is 0..2^BITS.
REQ-002 Parameter STEP_BITS, default 8, width of the step-interval counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 target_valid  input  1  new target duty offered.
REQ-006 target_ready  output  1  block can accept a target (high only in IDLE).
REQ-007 target  input  BITS+1  requested final duty.
REQ-008 step_size  input  BITS+1  duty change per step; sampled at acceptance.
REQ-009 step_interval  input  STEP_BITS  cycles between steps minus one; sampled at acceptance.
REQ-010 hold  input  1  freezes interval counter and duty while high.
REQ-011 duty  output  BITS+1  registered duty value driven to the PWM stage's duty input.
REQ-012 busy  output  1  high while in RAMP.
REQ-013 done  output  1  one-cycle pulse when duty reaches target.

Function
REQ-014 Two states, IDLE and RAMP; target_ready = (state==IDLE), busy = (state==RAMP), both decoded combinationally from state.
REQ-015 Acceptance occurs on a rising edge with target_valid & target_ready; target_valid outside IDLE is ignored and not queued.
REQ-016 At acceptance, target is clamped to 2^BITS, step_size 0 is treated as 1, and the clamped target, effective step, and step_interval are latched.
REQ-017 At acceptance, if the clamped target equals duty: state stays IDLE and done pulses in the following cycle.
REQ-018 At acceptance, if the clamped target differs from duty: state goes to RAMP and the interval counter clears to 0.
REQ-019 In RAMP with hold low, the interval counter increments each cycle.
REQ-020 When the interval counter equals the latched interval, a step occurs and the counter returns to 0.
REQ-021 The first duty change occurs at the (step_interval+1)th rising edge after the acceptance edge.
REQ-022 Step up, when duty < target: duty <= min(duty+step, target); the sum is computed at BITS+2 bits so it never wraps.
REQ-023 Step down, when duty > target: duty <= max(duty-step, target); no underflow below 0 or below target.
REQ-024 On the step edge that makes duty equal target: state returns to IDLE on that edge and done is high for exactly the next cycle.
REQ-025 With hold high in RAMP, the counter and duty keep their values; the ramp resumes where it left off after hold falls.
REQ-026 hold has no effect in IDLE; duty is stable in IDLE.
REQ-027 step_interval = 0 gives one step per cycle.
REQ-028 Changes to the target, step_size and step_interval inputs during RAMP have no effect.
REQ-029 duty changes only on step edges, so the downstream PWM sees monotonic single steps per step edge.

Reset
REQ-030 On a reset edge: state = IDLE, duty = 0, interval counter = 0, done = 0, latched registers = 0.
REQ-031 Reset asserted during RAMP aborts the ramp on that edge with no done pulse.
REQ-032 Reset has priority over acceptance presented in the same cycle.
REQ-033 target_ready is high in the first cycle after reset deasserts.

Verification (BITS=4, STEP_BITS=8)
REQ-034 Reset, then target=12, step=4, interval=2 -> duty 4, 8, 12 at edges 3, 6, 9 after acceptance; done high one cycle after edge 9; busy low from edge 9.
REQ-035 Ramp up to 16, then target=3, step=5, interval=0 -> duty 11, 6, 3 on consecutive edges; no value below 3.
REQ-036 target=31 from duty 0, step=16, interval=0 -> duty=16 after one edge; done follows.
REQ-037 hold high for 5 cycles mid-ramp -> duty and counter frozen for those cycles; total ramp time extended by exactly 5 cycles.
REQ-038 target equal to current duty -> no RAMP entry, done pulses next cycle.
REQ-039 target_valid during RAMP with a different target -> ignored; then reset mid-ramp -> duty=0, IDLE, no done pulse; step_size=0 -> steps of 1.
